// File: rtl/a_dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Read-during-write to the same address returns the new data (write-first).
// Synchronous active-high reset clears the whole array and the read register.
module a_dual_port_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  collide_c;
    logic [DATA_WIDTH-1:0] rd_next_c;

    // Next read value: bypass the incoming write data on a same-address collision
    always_comb begin
        collide_c = 1'b0;
        rd_next_c = mem[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            collide_c = 1'b1;
            rd_next_c = wr_data;
        end
    end

    // Storage array: cleared on reset, reset discards a coincident write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_WIDTH'(i)] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, updated every edge (no read enable)
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next_c;
        end
    end

endmodule

// File: tb/tb_a_dual_port_ram.sv
// Self-checking bench for a_dual_port_ram: directed test plan plus random traffic
// against an array-based reference model of the RAM's behaviour.
module tb_a_dual_port_ram;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_rd;
    bit            exp_valid = 1'b0;

    a_dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    // Unsupported input condition: unknown write enable outside reset
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            assert (!$isunknown(wr_en)) else begin
                errors++;
                $error("FAIL wr_en_known: observed=%b expected=0/1", wr_en);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // One clock cycle: drive inputs, confirm output holds, take the edge, check model
    task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [AW-1:0] ra, input string tag);
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
        #1;
        if (exp_valid) begin
            checks++;
            assert (rd_data === exp_rd) else begin
                errors++;
                $error("FAIL %s_hold: observed=%h expected=%h", tag, rd_data, exp_rd);
            end
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
            exp_rd = '0;
        end else begin
            exp_rd = (we && wa == ra) ? wd : ref_mem[ra];
            if (we) ref_mem[wa] = wd;
        end
        exp_valid = 1'b1;
        #1;
        checks++;
        assert (rd_data === exp_rd) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, rd_data, exp_rd);
        end
    endtask

    // Directed expectation taken straight from the test plan
    task automatic chk(input logic [DW-1:0] want, input string tag);
        checks++;
        assert (rd_data === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, rd_data, want);
        end
    endtask

    initial begin
        logic [DW-1:0] pat [5];
        pat[0] = 16'hA1A1; pat[1] = 16'hB2B2; pat[2] = 16'hC3C3;
        pat[3] = 16'hD4D4; pat[4] = 16'hE5E5;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Initial reset
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, "init_rst");
        chk(16'h0000, "init_rst_zero");
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, "init_rst2");

        // Arbitrary writes, then reset for 2 cycles, then read everything back as zero
        for (int i = 0; i < int'(DEPTH); i++)
            step(1'b0, 1'b1, AW'(i), DW'($urandom), AW'(i + 1), "pre_wr");
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd5, "rst_a");
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd6, "rst_b");
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(1'b0, 1'b0, 3'd0, 16'h0, AW'(i), "rst_rd");
            chk(16'h0000, "rst_rd_zero");
        end

        // Sequential write then read
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, AW'(i), pat[i], 3'd7, "seq_wr");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, AW'(i), 16'hFFFF, AW'(i), "seq_rd");
            chk(pat[i], "seq_rd_pat");
        end

        // Write-first collision
        step(1'b0, 1'b1, 3'd2, 16'h1234, 3'd2, "collide");
        chk(16'h1234, "collide_new");

        // Independent ports
        step(1'b0, 1'b1, 3'd7, 16'h5555, 3'd1, "indep");
        chk(16'hB2B2, "indep_old");
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd7, "indep_rd7");
        chk(16'h5555, "indep_new");

        // Write enable gating
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 3'd0, 16'hFFFF, 3'd4, "gate");
        step(1'b0, 1'b0, 3'd0, 16'hFFFF, 3'd0, "gate_rd");
        chk(16'hA1A1, "gate_a1");

        // Reset priority over a coincident write
        step(1'b1, 1'b1, 3'd3, 16'hDEAD, 3'd3, "rst_prio");
        chk(16'h0000, "rst_prio_zero");
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, "rst_prio_rd");
        chk(16'h0000, "rst_prio_rd3");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom), AW'($urandom),
                 DW'($urandom), AW'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
